// File: rtl/mmio_pkg.sv
// Shared constants and types for the MIPS data-memory access controller.
// The optional TX wait timeout is enabled by defining MMIO_TIMEOUT_EN.
package mmio_pkg;

    // Default data RAM base and peripheral word offsets from that base
    localparam logic [31:0] RAM_BASE_DEF = 32'h1001_0000;
    localparam logic [31:0] GPIO_OFS     = 32'h0000_0024;
    localparam logic [31:0] RX_OFS       = 32'h0000_0028;
    localparam logic [31:0] TX_OFS       = 32'h0000_002C;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAM_RD  = 2'd1,
        TX_WAIT = 2'd2,
        RESP    = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        T_RAM  = 3'd0,
        T_GPIO = 3'd1,
        T_RX   = 3'd2,
        T_TX   = 3'd3,
        T_ERR  = 3'd4
    } target_e;

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational address decoder: maps a CPU byte address to its target,
// the RAM word index and a misalignment flag. Peripheral words win over
// the RAM words they overlap. Alignment is reported separately so the
// controller decides how to treat a misaligned access.
module mmio_addr_decode
    import mmio_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE   = ADDR_WIDTH'(RAM_BASE_DEF),
    parameter int                    RAM_DEPTH  = 64
) (
    input  logic [ADDR_WIDTH-1:0]        addr_i,
    output target_e                      target_o,
    output logic [$clog2(RAM_DEPTH)-1:0] word_idx_o,
    output logic                         misaligned_o
);

    localparam int                    IDX_W     = $clog2(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] RAM_BYTES = ADDR_WIDTH'(4 * RAM_DEPTH);

    logic [ADDR_WIDTH-1:0] addr_w;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  in_ram;

    assign addr_w       = {addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign offset       = addr_w - RAM_BASE;
    // The lower-bound test keeps the subtraction from wrapping into range
    assign in_ram       = (addr_w >= RAM_BASE) && (offset < RAM_BYTES);
    assign misaligned_o = (addr_i[1:0] != 2'b00);
    assign word_idx_o   = offset[IDX_W+1:2];

    // Priority decode of the word-aligned address
    always_comb begin
        target_o = T_ERR;
        if (addr_w == RAM_BASE + ADDR_WIDTH'(GPIO_OFS)) begin
            target_o = T_GPIO;
        end else if (addr_w == RAM_BASE + ADDR_WIDTH'(RX_OFS)) begin
            target_o = T_RX;
        end else if (addr_w == RAM_BASE + ADDR_WIDTH'(TX_OFS)) begin
            target_o = T_TX;
        end else if (in_ram) begin
            target_o = T_RAM;
        end
    end

endmodule

// File: rtl/mmio_access_ctrl.sv
// MIPS data-memory access controller: sequences loads/stores onto data RAM,
// GPIO, UART RX and UART TX, stalling the core until each access completes
// with a one-cycle ack. Define MMIO_TIMEOUT_EN to bound the TX busy wait
// by TIMEOUT_CYCLES (timed-out stores ack with cpu_err and no tx_start).
//
// Handshake: the core raises cpu_req with cpu_we/cpu_addr/cpu_wdata stable
// and holds them until the single cycle in which cpu_ack=1; cpu_rdata and
// cpu_err are meaningful only in that cycle. Requests are taken only in
// IDLE, so a request still high during the ack cycle is not re-accepted.
module mmio_access_ctrl
    import mmio_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] RAM_BASE       = ADDR_WIDTH'(RAM_BASE_DEF),
    parameter int                    RAM_DEPTH      = 64,
    parameter int                    TIMEOUT_CYCLES = 1023
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [ADDR_WIDTH-1:0]        cpu_addr,
    input  logic [ADDR_WIDTH-1:0]        cpu_wdata,
    output logic [ADDR_WIDTH-1:0]        cpu_rdata,
    output logic                         cpu_ack,
    output logic                         cpu_stall,
    output logic                         cpu_err,
    output logic [$clog2(RAM_DEPTH)-1:0] ram_addr,
    output logic                         ram_we,
    output logic [ADDR_WIDTH-1:0]        ram_wdata,
    input  logic [ADDR_WIDTH-1:0]        ram_rdata,
    output logic [ADDR_WIDTH-1:0]        gpio_out,
    input  logic [ADDR_WIDTH-1:0]        gpio_in,
    output logic [7:0]                   tx_data,
    output logic                         tx_start,
    input  logic                         tx_busy,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_ready,
    output logic                         rx_clr,
    output logic [1:0]                   dbg_state
);

    localparam int IDX_W = $clog2(RAM_DEPTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic                  cpu_err_q, cpu_err_d;
    logic                  ram_we_q, ram_we_d;
    logic [IDX_W-1:0]      ram_addr_q, ram_addr_d;
    logic [ADDR_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic [ADDR_WIDTH-1:0] gpio_out_q, gpio_out_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_start_q, tx_start_d;
    logic                  rx_clr_q, rx_clr_d;

    target_e               dec_target;
    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_misaligned;
    logic                  ram_load_accept;

`ifdef MMIO_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    mmio_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_BASE   (RAM_BASE),
        .RAM_DEPTH  (RAM_DEPTH)
    ) u_decode (
        .addr_i       (cpu_addr),
        .target_o     (dec_target),
        .word_idx_o   (dec_idx),
        .misaligned_o (dec_misaligned)
    );

    // A RAM load presents its index in the acceptance cycle so the
    // synchronous read data is available during RAM_RD.
    assign ram_load_accept = (state_q == IDLE) && cpu_req && !cpu_we &&
                             !dec_misaligned && (dec_target == T_RAM);

    assign ram_addr  = ram_load_accept ? dec_idx : ram_addr_q;
    assign cpu_ack   = (state_q == RESP);
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_err   = cpu_err_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign gpio_out  = gpio_out_q;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign rx_clr    = rx_clr_q;
    assign dbg_state = state_q;

    // Next-state and register updates; strobes default low so each lasts one cycle
    always_comb begin
        state_d     = state_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_err_d   = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        gpio_out_d  = gpio_out_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = 1'b0;
        rx_clr_d    = 1'b0;
`ifdef MMIO_TIMEOUT_EN
        cnt_d       = '0;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    state_d = RESP;
                    if (dec_misaligned) begin
                        cpu_err_d   = 1'b1;
                        cpu_rdata_d = '0;
                    end else begin
                        case (dec_target)
                            T_RAM: begin
                                ram_addr_d = dec_idx;
                                if (cpu_we) begin
                                    ram_we_d    = 1'b1;
                                    ram_wdata_d = cpu_wdata;
                                end else begin
                                    state_d = RAM_RD;
                                end
                            end
                            T_GPIO: begin
                                if (cpu_we) gpio_out_d  = cpu_wdata;
                                else        cpu_rdata_d = gpio_in;
                            end
                            T_RX: begin
                                // Stores to the RX word are silently dropped
                                if (!cpu_we) begin
                                    cpu_rdata_d      = '0;
                                    cpu_rdata_d[8:0] = {rx_ready, rx_data};
                                    rx_clr_d         = rx_ready;
                                end
                            end
                            T_TX: begin
                                if (cpu_we) begin
                                    if (tx_busy) begin
                                        state_d = TX_WAIT;
                                    end else begin
                                        tx_data_d  = cpu_wdata[7:0];
                                        tx_start_d = 1'b1;
                                    end
                                end else begin
                                    cpu_rdata_d    = '0;
                                    cpu_rdata_d[0] = tx_busy;
                                end
                            end
                            default: begin
                                cpu_err_d   = 1'b1;
                                cpu_rdata_d = '0;
                            end
                        endcase
                    end
                end
            end
            RAM_RD: begin
                cpu_rdata_d = ram_rdata;
                state_d     = RESP;
            end
            TX_WAIT: begin
                if (!tx_busy) begin
                    tx_data_d  = cpu_wdata[7:0];
                    tx_start_d = 1'b1;
                    state_d    = RESP;
`ifdef MMIO_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    cpu_err_d   = 1'b1;
                    cpu_rdata_d = '0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access without a response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cpu_rdata_q <= '0;
            cpu_err_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            gpio_out_q  <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            rx_clr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_err_q   <= cpu_err_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            gpio_out_q  <= gpio_out_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            rx_clr_q    <= rx_clr_d;
        end
    end

`ifdef MMIO_TIMEOUT_EN
    // TX wait cycle counter, cleared whenever the FSM is outside TX_WAIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_mmio_access_ctrl.sv
// Directed bench for mmio_access_ctrl with a response scoreboard.
module tb_mmio_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_ack, cpu_stall, cpu_err;
    logic [5:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata, ram_rdata;
    logic [31:0] gpio_out, gpio_in;
    logic [7:0]  tx_data;
    logic        tx_start, tx_busy;
    logic [7:0]  rx_data;
    logic        rx_ready, rx_clr;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    mmio_access_ctrl dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .gpio_out(gpio_out), .gpio_in(gpio_in),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_ready(rx_ready), .rx_clr(rx_clr),
        .dbg_state(dbg_state)
    );

    typedef struct packed {
        logic        chk_rdata;
        logic [31:0] rdata;
        logic        err;
        logic        rx_clr;
        logic        tx_start;
        logic [7:0]  tx_data;
    } resp_t;

    resp_t       exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ram_we_cnt = 0;
    int          tx_start_cnt = 0;
    int          rx_clr_cnt = 0;
    int          busy_stall_cnt = 0;
    logic [5:0]  last_we_idx = '0;
    logic [31:0] last_we_data = '0;
    logic [31:0] mem [0:63];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic resp_t mk(input logic chk, input logic [31:0] rd, input logic err,
                                 input logic rxc, input logic txs, input logic [7:0] txd);
        resp_t r;
        r.chk_rdata = chk;
        r.rdata     = rd;
        r.err       = err;
        r.rx_clr    = rxc;
        r.tx_start  = txs;
        r.tx_data   = txd;
        return r;
    endfunction

    // Synchronous RAM model with one-cycle read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Monitor: pops the scoreboard on every ack and tallies strobes
    always @(negedge clk) begin
        resp_t e;
        if (reset && cpu_ack) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack at %0t, expected none", $time);
            end else begin
                e = exp_q.pop_front();
                if (e.chk_rdata) check("ack_rdata", cpu_rdata, e.rdata);
                check("ack_err", 32'(cpu_err), 32'(e.err));
                check("ack_rx_clr", 32'(rx_clr), 32'(e.rx_clr));
                check("ack_tx_start", 32'(tx_start), 32'(e.tx_start));
                if (e.tx_start) check("ack_tx_data", 32'(tx_data), 32'(e.tx_data));
            end
        end
        if (ram_we) begin
            ram_we_cnt++;
            last_we_idx  = ram_addr;
            last_we_data = ram_wdata;
        end
        if (tx_start) tx_start_cnt++;
        if (rx_clr) rx_clr_cnt++;
        if (tx_busy && cpu_stall) busy_stall_cnt++;
    end

    // Driver: issue one access, hold it until ack (bounded), return latency
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input resp_t e, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        exp_q.push_back(e);
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_req   = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cpu_ack) begin
                got = 1'b1;
                break;
            end
            lat++;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout: got no ack for addr 0x%08h, expected ack within 200 cycles", addr);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    initial begin
        int lat;
        int base_we, base_txs, base_rxc, base_stall;

        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        gpio_in = '0; tx_busy = 1'b0; rx_data = '0; rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(cpu_ack), 32'd0);
        check("rst_err", 32'(cpu_err), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_rx_clr", 32'(rx_clr), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_gpio_out", gpio_out, 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // RAM store then load of word 1
        access(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, mk(0, 0, 0, 0, 0, 0), lat);
        check("ram_st_lat", 32'(lat), 32'd1);
        check("ram_we_count", 32'(ram_we_cnt), 32'd1);
        check("ram_we_idx", 32'(last_we_idx), 32'd1);
        check("ram_we_data", last_we_data, 32'hDEAD_BEEF);
        access(1'b0, 32'h1001_0004, 32'h0, mk(1, 32'hDEAD_BEEF, 0, 0, 0, 0), lat);
        check("ram_ld_lat", 32'(lat), 32'd2);

        // Last RAM word, word next to GPIO, and both range edges
        access(1'b1, 32'h1001_00FC, 32'h1234_5678, mk(0, 0, 0, 0, 0, 0), lat);
        check("ram_last_idx", 32'(last_we_idx), 32'd63);
        access(1'b1, 32'h1001_0020, 32'hCAFE_F00D, mk(0, 0, 0, 0, 0, 0), lat);
        check("ram_w8_idx", 32'(last_we_idx), 32'd8);
        access(1'b0, 32'h1001_00FC, 32'h0, mk(1, 32'h1234_5678, 0, 0, 0, 0), lat);
        access(1'b0, 32'h1001_0020, 32'h0, mk(1, 32'hCAFE_F00D, 0, 0, 0, 0), lat);
        base_we = ram_we_cnt;
        access(1'b1, 32'h1001_0100, 32'h1111_1111, mk(1, 32'h0, 1, 0, 0, 0), lat);
        access(1'b0, 32'h1000_FFFC, 32'h0, mk(1, 32'h0, 1, 0, 0, 0), lat);
        check("ram_oob_no_we", 32'(ram_we_cnt - base_we), 32'd0);

        // TX store with transmitter idle: immediate start
        access(1'b1, 32'h1001_002C, 32'h0000_01A5, mk(0, 0, 0, 0, 1, 8'hA5), lat);
        check("tx_idle_lat", 32'(lat), 32'd1);

        // TX store while busy for 5 cycles
        base_txs   = tx_start_cnt;
        base_stall = busy_stall_cnt;
        tx_busy    = 1'b1;
        fork
            access(1'b1, 32'h1001_002C, 32'h0000_005A, mk(0, 0, 0, 0, 1, 8'h5A), lat);
            begin
                repeat (5) @(posedge clk);
                #1;
                tx_busy = 1'b0;
            end
        join
        check("tx_busy_stall", 32'(busy_stall_cnt - base_stall), 32'd5);
        check("tx_start_once", 32'(tx_start_cnt - base_txs), 32'd1);
        check("tx_busy_lat", 32'(lat), 32'd6);

        // TX status loads
        tx_busy = 1'b1;
        access(1'b0, 32'h1001_002C, 32'h0, mk(1, 32'h1, 0, 0, 0, 0), lat);
        tx_busy = 1'b0;
        access(1'b0, 32'h1001_002C, 32'h0, mk(1, 32'h0, 0, 0, 0, 0), lat);

        // RX loads with and without the ready flag, then an ignored store
        base_rxc = rx_clr_cnt;
        rx_ready = 1'b1;
        rx_data  = 8'h41;
        access(1'b0, 32'h1001_0028, 32'h0, mk(1, 32'h0000_0141, 0, 1, 0, 0), lat);
        rx_ready = 1'b0;
        access(1'b0, 32'h1001_0028, 32'h0, mk(1, 32'h0000_0041, 0, 0, 0, 0), lat);
        access(1'b1, 32'h1001_0028, 32'hFFFF_FFFF, mk(0, 0, 0, 0, 0, 0), lat);
        check("rx_clr_count", 32'(rx_clr_cnt - base_rxc), 32'd1);

        // Misaligned and unmapped accesses: error, no side effects
        base_we  = ram_we_cnt;
        base_txs = tx_start_cnt;
        base_rxc = rx_clr_cnt;
        rx_ready = 1'b1;
        access(1'b0, 32'h1001_0026, 32'h0, mk(1, 32'h0, 1, 0, 0, 0), lat);
        check("err_lat", 32'(lat), 32'd1);
        access(1'b0, 32'h2000_0000, 32'h0, mk(1, 32'h0, 1, 0, 0, 0), lat);
        access(1'b0, 32'h1001_002A, 32'h0, mk(1, 32'h0, 1, 0, 0, 0), lat);
        access(1'b1, 32'h1001_0005, 32'hFFFF_FFFF, mk(1, 32'h0, 1, 0, 0, 0), lat);
        access(1'b1, 32'h1001_002D, 32'hFFFF_FFFF, mk(1, 32'h0, 1, 0, 0, 0), lat);
        rx_ready = 1'b0;
        check("err_no_ram_we", 32'(ram_we_cnt - base_we), 32'd0);
        check("err_no_tx_start", 32'(tx_start_cnt - base_txs), 32'd0);
        check("err_no_rx_clr", 32'(rx_clr_cnt - base_rxc), 32'd0);

        // GPIO store and load; the overlapped RAM word is not written
        base_we = ram_we_cnt;
        access(1'b1, 32'h1001_0024, 32'h0000_000F, mk(0, 0, 0, 0, 0, 0), lat);
        check("gpio_out", gpio_out, 32'h0000_000F);
        check("gpio_no_ram_we", 32'(ram_we_cnt - base_we), 32'd0);
        gpio_in = 32'h0000_00A5;
        access(1'b0, 32'h1001_0024, 32'h0, mk(1, 32'h0000_00A5, 0, 0, 0, 0), lat);

        // Reset asserted while waiting on a busy transmitter
        base_txs  = tx_start_cnt;
        tx_busy   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h1001_002C;
        cpu_wdata = 32'h0000_0077;
        cpu_req   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("txwait_state", 32'(dbg_state), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("abort_state", 32'(dbg_state), 32'd0);
        check("abort_ack", 32'(cpu_ack), 32'd0);
        check("abort_gpio_out", gpio_out, 32'd0);
        check("abort_tx_data", 32'(tx_data), 32'd0);
        check("abort_rdata", cpu_rdata, 32'd0);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        tx_busy = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_tx_start", 32'(tx_start_cnt - base_txs), 32'd0);

        // Recovery after reset
        gpio_in = 32'h0000_003C;
        access(1'b0, 32'h1001_0024, 32'h0, mk(1, 32'h0000_003C, 0, 0, 0, 0), lat);

        repeat (2) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mmio_access_ctrl.md
Name: mmio_access_ctrl

Overview:
- Sequences every MIPS data-memory access onto the data RAM, GPIO, UART RX and UART TX.
- Decodes the MIPS virtual address and stalls the core until the target completes.
- Generates the one-cycle RAM word index, TX start pulse and RX flag clear.
- Sits between the core's load/store stage and the RAM/peripheral write-back mux. It is the single owner of those resources.

Parameters:
- ADDR_WIDTH, 32, CPU address/data width.
- RAM_BASE, 32'h10010000, data RAM base address.
- RAM_DEPTH, 64, RAM size in words; RAM index width = $clog2(RAM_DEPTH).
- TIMEOUT_CYCLES, 1023, TX wait limit; used only with MMIO_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  access request; held high until cpu_ack.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_WIDTH  byte address.
- cpu_wdata  in  ADDR_WIDTH  store data.
- cpu_rdata  out  ADDR_WIDTH  load data; valid only with cpu_ack.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  = cpu_req & ~cpu_ack.
- cpu_err  out  1  one-cycle pulse with cpu_ack on misaligned, unmapped or timeout access.
- ram_addr  out  $clog2(RAM_DEPTH)  word index = (addr-RAM_BASE)>>2.
- ram_we  out  1  RAM write strobe.
- ram_wdata  out  ADDR_WIDTH  RAM write data.
- ram_rdata  in  ADDR_WIDTH  synchronous RAM read data; 1-cycle latency.
- gpio_out  out  ADDR_WIDTH  GPIO output register.
- gpio_in  in  ADDR_WIDTH  GPIO input.
- tx_data  out  8  UART TX byte (registered).
- tx_start  out  1  one-cycle TX start pulse.
- tx_busy  in  1  UART transmitter busy.
- rx_data  in  8  UART received byte.
- rx_ready  in  1  UART RX flag.
- rx_clr  out  1  one-cycle RX flag clear pulse.

Behaviour:
- Reset (reset=0, async): state IDLE. cpu_ack, cpu_err, ram_we, tx_start, rx_clr=0. cpu_rdata, gpio_out, tx_data, ram_addr, ram_wdata=0.
- Reset asserted mid-operation aborts the access without ack. No tx_start or rx_clr is issued.
- Decode priority, word-aligned addresses:
  - RAM_BASE+0x24 → GPIO.
  - RAM_BASE+0x28 → RX.
  - RAM_BASE+0x2C → TX.
  - else RAM_BASE ≤ addr < RAM_BASE+4*RAM_DEPTH → RAM.
  - else unmapped.
  - Peripheral decode overrides the RAM words it overlaps.
- Error: addr[1:0]≠0 or unmapped → no side effects. Next cycle: cpu_ack=1, cpu_err=1, cpu_rdata=0.
- FSM states: IDLE, RAM_RD, TX_WAIT, RESP.
  - Requests are sampled only in IDLE.
  - Every access asserts cpu_ack exactly one cycle, then returns to IDLE.
  - Minimum latency: ack in the cycle after acceptance.
- RAM store (IDLE→RESP):
  - ram_we pulses 1 cycle on the acceptance edge+0, with ram_addr and ram_wdata registered.
  - Ack the next cycle.
- RAM load (IDLE→RAM_RD→RESP):
  - ram_addr is driven at acceptance.
  - ram_rdata is captured in RAM_RD.
  - Ack in RESP (2-cycle latency).
- GPIO: store → gpio_out<=cpu_wdata. Load → cpu_rdata=gpio_in. Both go IDLE→RESP.
- RX:
  - Load → cpu_rdata={23'b0, rx_ready, rx_data}.
  - rx_clr pulses with cpu_ack only if the returned rx_ready bit was 1.
  - Store is ignored without error.
- TX:
  - Load → cpu_rdata={31'b0, tx_busy}.
  - Store → TX_WAIT while tx_busy=1.
  - When tx_busy=0: tx_data<=cpu_wdata[7:0], tx_start pulse, ack in the same cycle.
- Simultaneous events:
  - A new cpu_req in the ack cycle is not accepted; the core must drop or re-hold it.
  - A tx_busy fall and rise in the same cycle is sampled as registered.
  - The UART must give new-byte arrival priority over rx_clr.
- Width rule: ram_addr uses truncated (addr-RAM_BASE)>>2. The range check guarantees no wrap.

Optional Feature:
- MMIO_TIMEOUT_EN defined:
  - A counter runs in TX_WAIT.
  - On reaching TIMEOUT_CYCLES: ack with cpu_err=1, no tx_start, counter cleared.
  - The counter also clears on leaving TX_WAIT.
- MMIO_TIMEOUT_EN undefined: no counter; TX_WAIT waits indefinitely; TIMEOUT_CYCLES unused.

Decomposition:
- mmio_pkg holds:
  - Address constants: GPIO_OFS 0x24, RX_OFS 0x28, TX_OFS 0x2C, RAM_BASE default.
  - State enum {IDLE, RAM_RD, TX_WAIT, RESP}.
  - Target enum {T_RAM, T_GPIO, T_RX, T_TX, T_ERR}.
- Sub-module mmio_addr_decode (combinational): cpu_addr → target, word index, misaligned flag.
- The FSM and registers live in mmio_access_ctrl.

Test Plan:
- Store 0xDEADBEEF @0x10010004, then load @0x10010004 → ram_we once at index 1; load acks 2 cycles after acceptance with 0xDEADBEEF.
- Store 0x5A @0x1001002C with tx_busy=1 for 5 cycles → stall 5 cycles; tx_start pulses once with tx_data=0x5A coincident with ack.
- rx_ready=1, rx_data=0x41, load @0x10010028 → cpu_rdata=0x00000141 and rx_clr pulse. Repeat with rx_ready=0 → 0x00000041, no rx_clr.
- Load @0x10010026 and @0x20000000 → cpu_err=1 with ack, cpu_rdata=0, no RAM/peripheral strobes.
- Store 0x0F @0x10010024, then load with gpio_in=0xA5 → gpio_out=0x0F, cpu_rdata=0xA5.
- reset low during TX_WAIT → all outputs 0 immediately. With MMIO_TIMEOUT_EN and tx_busy stuck → cpu_err at cycle 1023, no tx_start.
